lib_fifo_packet: RTL and testbench
==================================

// Module: lib_fifo_packet
// PURPOSE
// - Synchronous, first-word-fall-through FIFO that stores packet_t words (type from the ENoC config package).
// - Library buffer used in router input ports and network endpoints.
// - Upstream writes with a valid/enable handshake; downstream sees the head word combinationally
//   and pops it with i_en.
// PARAMETERS
// - DEPTH  4  Number of packet_t entries. Must be >= 2; any value is legal, pointers wrap explicitly at DEPTH-1.
// PORTS
// - clk           in   1                  Single clock; all state changes on its rising edge.
// - reset         in   1                  Asynchronous, active-high reset.
// - ce            in   1                  Clock enable; when 0, all registers hold.
// - i_data        in   packet_t           Write data from upstream.
// - i_data_val    in   1                  Write request; i_data is valid.
// - i_en          in   1                  Read acknowledge from downstream; pops the head word.
// - o_data        out  packet_t           Head word (mem[rd_ptr]), combinational.
// - o_data_val    out  1                  Head word valid (= ~o_empty).
// - o_en          out  1                  Ready to upstream (= ~o_full | i_en).
// - o_empty       out  1                  Count == 0.
// - o_near_empty  out  1                  Count <= 1.
// - o_full        out  1                  Count == DEPTH.
// - o_near_full   out  1                  Count >= DEPTH-1.
// BEHAVIOUR
// - State:
//   - Storage array mem[DEPTH] is not reset.
//   - wr_ptr and rd_ptr are clog2(DEPTH) bits wide.
//   - count is clog2(DEPTH+1) bits wide.
//   - All flags are decoded from count.
// - Reset (asynchronous, reset=1):
//   - wr_ptr=0, rd_ptr=0, count=0.
//   - Outputs: o_empty=1, o_near_empty=1, o_full=0, o_near_full=0, o_data_val=0, o_en=1.
//   - Reset mid-operation discards all stored words immediately.
// - wr = i_data_val & o_en (write accepted when not full, or when full with a simultaneous read).
// - rd = i_en & ~o_empty.
//   - i_en while empty is ignored.
//   - A write into an empty FIFO cannot be read in the same cycle.
// - On rising clk with ce=1:
//   - wr: mem[wr_ptr] <= i_data; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
//   - rd: rd_ptr advances with the same wrap rule.
//   - count: +1 on wr only, -1 on rd only, unchanged on both or neither.
// - ce=0: no pointer, count or memory change; outputs still reflect current state.
// - Latency:
//   - A word written at edge N appears on o_data with o_data_val=1 after edge N (FWFT, one-cycle write-to-read).
//   - A pop at edge N presents the next word after edge N.
// - Full with i_en=1 and i_data_val=1: pop and push in the same cycle, count stays DEPTH, o_full stays 1.
// - o_data is unspecified while o_data_val=0; verification must not check it then.
// - Ordering: strict FIFO; no drops, no duplication.
// TESTING
// - Reset then release, write D with i_en=0 -> next cycle o_data.data=D, o_data_val=1, o_empty=0;
//   assert i_en -> next cycle o_empty=1, o_data_val=0.
// - Write D,E,A,D on consecutive cycles -> o_full=1, o_near_full=1, o_en=0;
//   extra write B with i_en=0 -> ignored, head remains D.
// - Full, apply i_en=1 with writes B,E,E,F -> heads D,E,A,D are popped in order; o_full stays 1;
//   stored order becomes B,E,E,F.
// - Drain with i_data_val=0, i_en=1 -> outputs B,E,E,F; then o_empty=1; further i_en has no effect on count.
// - Continuous write of an incrementing counter with i_en toggling every cycle -> output sequence 0,1,2,...
//   with no gaps or repeats; fills to o_full and holds o_en=0 only when i_en=0.
// - Assert reset while 3 words are stored -> flags return to reset values asynchronously;
//   ce=0 for several cycles -> no state change.

Source files
------------

// File: rtl/lib_fifo_packet.sv
// lib_fifo_packet: first-word-fall-through packet FIFO with count-decoded flags
// Head word is presented combinationally; a push into an empty FIFO is visible after the edge.
module lib_fifo_packet #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_data_val,
   input  logic              i_en,
   output logic [DATA_W-1:0] o_data,
   output logic              o_data_val,
   output logic              o_en,
   output logic              o_empty,
   output logic              o_near_empty,
   output logic              o_full,
   output logic              o_near_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic wr, rd;
   assign o_empty      = count_q == '0;
   assign o_near_empty = count_q <= CW'(1);
   assign o_full       = count_q == CW'(DEPTH);
   assign o_near_full  = count_q >= CW'(DEPTH - 1);
   assign o_data_val   = ~o_empty;
   assign o_en         = ~o_full | i_en;
   assign o_data       = mem[rd_ptr_q];
   assign wr = i_data_val & o_en;
   assign rd = i_en & ~o_empty;
   // pointers wrap explicitly so non-power-of-two depths stay in range
   always_comb begin
      wr_ptr_d = wr ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = rd ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
      count_d  = count_q + CW'(wr & ~rd) - CW'(rd & ~wr);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (ce) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (ce && wr) mem[wr_ptr_q] <= i_data;
   end
endmodule

// File: tb/tb_lib_fifo_packet.sv
// tb_lib_fifo_packet: directed and random stimulus checked against a queue model of the FIFO
module tb_lib_fifo_packet;
   localparam int DEPTH = 4;
   localparam int W = 16;
   logic clk = 1'b0;
   logic reset, ce, i_data_val, i_en;
   logic [W-1:0] i_data, o_data;
   logic o_data_val, o_en, o_empty, o_near_empty, o_full, o_near_full;
   int total = 0;
   int bad = 0;
   logic [W-1:0] q[$];
   logic [W-1:0] cnt;
   always #5 clk = ~clk;
   lib_fifo_packet #(.DEPTH(DEPTH), .DATA_W(W)) dut (
      .clk(clk), .reset(reset), .ce(ce), .i_data(i_data), .i_data_val(i_data_val), .i_en(i_en),
      .o_data(o_data), .o_data_val(o_data_val), .o_en(o_en), .o_empty(o_empty),
      .o_near_empty(o_near_empty), .o_full(o_full), .o_near_full(o_near_full)
   );
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".empty"}, W'(o_empty), W'(n == 0));
      chk({tag, ".near_empty"}, W'(o_near_empty), W'(n <= 1));
      chk({tag, ".full"}, W'(o_full), W'(n == DEPTH));
      chk({tag, ".near_full"}, W'(o_near_full), W'(n >= DEPTH - 1));
      chk({tag, ".data_val"}, W'(o_data_val), W'(n != 0));
      chk({tag, ".en"}, W'(o_en), W'((n < DEPTH) || i_en));
      if (n > 0) chk({tag, ".data"}, o_data, q[0]);
   endtask
   task automatic step(input string tag, input logic dv, input logic [W-1:0] d, input logic en,
                       input logic c = 1'b1);
      logic wr, rd;
      i_data_val = dv;
      i_data = d;
      i_en = en;
      ce = c;
      wr = dv && ((q.size() < DEPTH) || en);
      rd = en && (q.size() > 0);
      @(posedge clk);
      #1;
      if (c) begin
         if (rd) void'(q.pop_front());
         if (wr) q.push_back(d);
      end
      chk_all(tag);
   endtask
   initial begin
      reset = 1'b1; ce = 1'b1; i_data_val = 1'b0; i_en = 1'b0; i_data = '0;
      #12;
      chk_all("reset");
      @(negedge clk);
      reset = 1'b0;
      step("wr1", 1'b1, 16'hD, 1'b0);
      chk("wr1.head", o_data, 16'hD);
      step("pop1", 1'b0, '0, 1'b1);
      chk("pop1.empty", W'(o_empty), W'(1));
      step("fill_d", 1'b1, 16'hD, 1'b0);
      step("fill_e", 1'b1, 16'hE, 1'b0);
      step("fill_a", 1'b1, 16'hA, 1'b0);
      step("fill_d2", 1'b1, 16'hD, 1'b0);
      chk("fill.full", W'(o_full), W'(1));
      chk("fill.en", W'(o_en), W'(0));
      step("full_ign", 1'b1, 16'hB, 1'b0);
      chk("full_ign.head", o_data, 16'hD);
      step("swap_b", 1'b1, 16'hB, 1'b1);
      chk("swap_b.head", o_data, 16'hE);
      step("swap_e", 1'b1, 16'hE, 1'b1);
      step("swap_e2", 1'b1, 16'hE, 1'b1);
      step("swap_f", 1'b1, 16'hF, 1'b1);
      chk("swap.full", W'(o_full), W'(1));
      chk("swap.head", o_data, 16'hB);
      for (int i = 0; i < 6; i++) step("drain", 1'b0, '0, 1'b1);
      chk("drain.empty", W'(o_empty), W'(1));
      cnt = '0;
      for (int i = 0; i < 40; i++) begin
         logic en, acc;
         en = (i % 2) == 1;
         acc = (q.size() < DEPTH) || en;
         step("count", 1'b1, cnt, en);
         if (acc) cnt++;
      end
      while (q.size() > 0) step("drain2", 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step("three", 1'b1, W'($urandom), 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      q.delete();
      chk_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      step("post_rst", 1'b1, 16'h55, 1'b0);
      step("post_rst2", 1'b1, 16'h66, 1'b0);
      for (int i = 0; i < 5; i++)
         step("ce_hold", 1'($urandom), W'($urandom), 1'($urandom), 1'b0);
      chk("ce_hold.head", o_data, 16'h55);
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
